morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Receiver counterpart to the lab Morse letter transmitter (letters A–H, index 0–7).
- Watches the serial DotDashIn line (one symbol element every CLOCK_FREQUENCY/2 clocks), self-synchronises on the leading rising edge and samples 12 elements at mid-bit.
- Matches the captured 12-bit word against the 8-letter code table and reports the decoded letter index, or an error, with one-cycle strobes.
- Sits on the same ClockIn domain as the transmitter; intended for loopback test of the transmitter and for HEX/LED display of received letters.

Parameters:
CLOCK_FREQUENCY, 8, ClockIn cycles per 2 symbol elements; element period P = CLOCK_FREQUENCY/2; legal values: even, >= 2.

Ports:
ClockIn  input  1  system clock, rising-edge.
Resetn  input  1  asynchronous, active-low reset.
DotDashIn  input  1  serial Morse line, synchronous to ClockIn; 1 = tone, 0 = gap.
Letter  output  3  last decoded letter index (0=A … 7=H); held between decodes.
LetterValid  output  1  one-cycle pulse: Letter just updated with a matched code.
LetterError  output  1  one-cycle pulse: 12-element word matched no table entry.
Busy  output  1  high while a letter is being received (state RECV or DECODE).

Behaviour:
- Reset (Resetn=0, any time, asynchronous): state=IDLE, Letter=0, LetterValid=0, LetterError=0, Busy=0, shift register=0, counters=0, prev-line register=1. Deasserting reset with the line held high therefore does not start a receive.
- Constants: P = CLOCK_FREQUENCY/2; H = P/2, truncated (P=4 -> H=2; P=1 -> H=0).
- Phase counter width: $clog2(P)+1. Element counter: 4 bits, counts 0..11.
- Code table, MSB = first element:
  - 0: 101110000000
  - 1: 111010101000
  - 2: 111010111010
  - 3: 111010100000
  - 4: 100000000000
  - 5: 101011101000
  - 6: 111011101000
  - 7: 101010100000
- IDLE:
  - Busy=0. Start condition is a rising edge: prev=0 and DotDashIn=1 at a clock edge t0.
  - On start: go to RECV, load phase counter with H, clear element counter.
  - prev is updated from DotDashIn every cycle in every state.
- RECV:
  - Busy=1. The phase counter decrements each cycle.
  - When the phase counter reaches 0: shift DotDashIn into the LSB of a 12-bit register, increment the element counter, reload the phase counter with P-1.
  - Sample k (k=0..11) is therefore taken at edge t0+H+k*P.
  - Glitch reject: if sample 0 is 0, return to IDLE with no strobe and Letter unchanged.
  - Rising edges on the line during RECV are ignored; they are not restarts.
  - After sample 11: go to DECODE.
- DECODE (exactly one cycle):
  - Compare the 12-bit word against the table.
  - Match i: Letter<=i, LetterValid=1.
  - No match: LetterError=1, Letter unchanged.
  - Next state is IDLE.
  - Strobes are registered and high exactly during the cycle after edge t0+H+11P+1. For P=4 that is the edge at t0+47.
- LetterValid and LetterError are never both 1. Neither strobe repeats without a new start.
- Back-to-back letters: a rising edge arriving any cycle after DECODE starts a new receive. A line still high when IDLE is re-entered does not start until it has gone low and then high again.

Test Plan:
- E (P=4): DotDashIn high 4 cycles from t0, then low 44 cycles -> LetterValid pulse one cycle at t0+47 with Letter=4; LetterError stays 0; Busy high from t0+1 through the DECODE cycle.
- C (P=4): drive 111010111010, each element held 4 cycles -> Letter=2 with LetterValid pulse. Then send A (101110000000) immediately after -> second LetterValid pulse with Letter=0.
- Glitch: 1-cycle high pulse on an otherwise low line (P=4) -> sample 0 is 0, return to IDLE; no strobe, Letter unchanged, Busy back to 0 by t0+3.
- Invalid code: drive 111111111111 -> LetterError pulse one cycle; LetterValid stays 0; Letter keeps its previous value (e.g. 2).
- Reset mid-receive: assert Resetn=0 between clock edges after sample 5 of letter B -> all outputs 0 immediately, with no clock edge needed. Release reset, then send D (111010100000) -> Letter=3 with LetterValid pulse; the partial B word is not reported.
- Parameter sweep: CLOCK_FREQUENCY=2 (P=1, H=0) and CLOCK_FREQUENCY=16 (P=8). Send all 8 letters through a transmitter-style stimulus at each setting -> all 8 decoded correctly, with the strobe at edge t0+H+11P+1.

Source files
------------

// File: rtl/morse_decoder.sv
// Morse letter receiver (A-H): syncs on the leading rising edge, samples 12 elements
// at mid-element and matches the word against the letter table.
module morse_decoder #(
  parameter int CLOCK_FREQUENCY = 8
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       DotDashIn,
  output logic [2:0] Letter,
  output logic       LetterValid,
  output logic       LetterError,
  output logic       Busy
);

  localparam int P  = CLOCK_FREQUENCY / 2;
  localparam int H  = P / 2;
  localparam int PW = $clog2(P) + 1;
  // The start edge itself counts as one tick, so the first wait is H-1.
  localparam logic [PW-1:0] PRELOAD = (H > 0) ? PW'(H - 1) : '0;
  localparam logic [PW-1:0] RELOAD  = PW'(P - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DECODE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    elem_q, elem_d;
  logic [11:0]   shift_q, shift_d;
  logic          prev_q;
  logic [2:0]    letter_q, letter_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;
  logic [3:0]    hit_s;

  function automatic logic [3:0] lookup(input logic [11:0] w);
    logic [3:0] r;
    case (w)
      12'b101110000000: r = 4'b1000;
      12'b111010101000: r = 4'b1001;
      12'b111010111010: r = 4'b1010;
      12'b111010100000: r = 4'b1011;
      12'b100000000000: r = 4'b1100;
      12'b101011101000: r = 4'b1101;
      12'b111011101000: r = 4'b1110;
      12'b101010100000: r = 4'b1111;
      default:          r = 4'b0000;
    endcase
    return r;
  endfunction

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      elem_q   <= 4'd0;
      shift_q  <= 12'd0;
      prev_q   <= 1'b1;
      letter_q <= 3'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      elem_q   <= elem_d;
      shift_q  <= shift_d;
      prev_q   <= DotDashIn;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    elem_d   = elem_q;
    shift_d  = shift_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    hit_s    = lookup(shift_q);
    case (state_q)
      S_IDLE: begin
        if (!prev_q && DotDashIn) begin
          state_d = S_RECV;
          // With H=0 sample 0 falls on the start edge and is the known-high line.
          if (H == 0) begin
            shift_d = {shift_q[10:0], 1'b1};
            elem_d  = 4'd1;
            phase_d = RELOAD;
          end else begin
            elem_d  = 4'd0;
            phase_d = PRELOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        if (phase_q == '0) begin
          shift_d = {shift_q[10:0], DotDashIn};
          elem_d  = elem_q + 4'd1;
          phase_d = RELOAD;
          if (elem_q == 4'd0 && !DotDashIn) begin
            state_d = S_IDLE;
          end else if (elem_q == 4'd11) begin
            state_d = S_DECODE;
            elem_d  = 4'd0;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      S_DECODE: begin
        if (hit_s[3]) begin
          letter_d = hit_s[2:0];
          valid_d  = 1'b1;
        end else begin
          error_d  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign Letter      = letter_q;
  assign LetterValid = valid_q;
  assign LetterError = error_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder at CLOCK_FREQUENCY = 8, 2 and 16.
module tb_morse_decoder;

  logic       clk;
  logic       rst_n;
  logic [2:0] dd;
  logic [2:0] letter_s [3];
  logic [2:0] valid_s;
  logic [2:0] error_s;
  logic [2:0] busy_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_letter [3];
  int per_p [3] = '{4, 1, 8};

  typedef struct {
    int d;
    int letter;
    int err;
    int due;
  } exp_t;
  exp_t sb [$];

  logic [11:0] code [8] = '{12'b101110000000, 12'b111010101000, 12'b111010111010,
                            12'b111010100000, 12'b100000000000, 12'b101011101000,
                            12'b111011101000, 12'b101010100000};

  morse_decoder #(.CLOCK_FREQUENCY(8)) u_dut8 (
    .ClockIn(clk), .Resetn(rst_n), .DotDashIn(dd[0]), .Letter(letter_s[0]),
    .LetterValid(valid_s[0]), .LetterError(error_s[0]), .Busy(busy_s[0]));
  morse_decoder #(.CLOCK_FREQUENCY(2)) u_dut2 (
    .ClockIn(clk), .Resetn(rst_n), .DotDashIn(dd[1]), .Letter(letter_s[1]),
    .LetterValid(valid_s[1]), .LetterError(error_s[1]), .Busy(busy_s[1]));
  morse_decoder #(.CLOCK_FREQUENCY(16)) u_dut16 (
    .ClockIn(clk), .Resetn(rst_n), .DotDashIn(dd[2]), .Letter(letter_s[2]),
    .LetterValid(valid_s[2]), .LetterError(error_s[2]), .Busy(busy_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives the first nel elements of w, each held P cycles; a full word is scored.
  task automatic send(input int d, input logic [11:0] w, input int nel);
    int p, h, t0, idx, n;
    exp_t e;
    p   = per_p[d];
    h   = p / 2;
    t0  = cyc + 1;
    idx = -1;
    for (int i = 0; i < 8; i++) if (code[i] == w) idx = i;
    if (nel == 12) begin
      e.d      = d;
      e.err    = (idx < 0) ? 1 : 0;
      e.letter = (idx < 0) ? last_letter[d] : idx;
      e.due    = t0 + h + 11 * p + 1;
      last_letter[d] = e.letter;
      sb.push_back(e);
    end
    for (int k = 0; k < nel; k++) begin
      dd[d] = w[11-k];
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        n = k * p + c;
        if (n == 0) check_val("busy_start", int'(busy_s[d]), 1);
        if (nel == 12 && n == h + 11 * p) check_val("busy_decode", int'(busy_s[d]), 1);
        if (nel == 12 && n == h + 11 * p + 1) check_val("busy_end", int'(busy_s[d]), 0);
      end
    end
    dd[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n);
    dd[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Pops the scoreboard whenever any decoder strobes.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (valid_s[d] || error_s[d]) begin
        check_val("strobe_excl", int'(valid_s[d] & error_s[d]), 0);
        if (sb.size() == 0) begin
          check_val("unexpected_strobe", d, -1);
        end else begin
          e = sb.pop_front();
          check_val("sb_dut", d, e.d);
          check_val("sb_err", int'(error_s[d]), e.err);
          check_val("sb_letter", int'(letter_s[d]), e.letter);
          check_val("sb_time", cyc, e.due);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    dd    = 3'b000;
    for (int d = 0; d < 3; d++) last_letter[d] = 0;
    repeat (3) @(negedge clk);
    check_val("rst_letter", int'(letter_s[0]), 0);
    check_val("rst_busy", int'(busy_s[0]), 0);
    check_val("rst_valid", int'(valid_s[0]), 0);
    check_val("rst_error", int'(error_s[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, code[4], 12);
    idle(0, 4);
    send(0, code[2], 12);
    send(0, code[0], 12);
    idle(0, 4);

    dd[0] = 1'b1;
    @(negedge clk);
    dd[0] = 1'b0;
    repeat (2) @(negedge clk);
    check_val("glitch_busy", int'(busy_s[0]), 0);
    check_val("glitch_letter", int'(letter_s[0]), last_letter[0]);
    idle(0, 60);

    send(0, code[2], 12);
    idle(0, 4);
    send(0, 12'b111111111111, 12);
    idle(0, 6);
    check_val("err_letter_kept", int'(letter_s[0]), 2);

    send(0, code[1], 6);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_letter", int'(letter_s[0]), 0);
    check_val("arst_busy", int'(busy_s[0]), 0);
    check_val("arst_valid", int'(valid_s[0]), 0);
    check_val("arst_error", int'(error_s[0]), 0);
    last_letter[0] = 0;
    dd[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(0, 4);
    send(0, code[3], 12);
    idle(0, 4);

    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        send(d, code[i], 12);
        idle(d, 3);
      end
    end

    idle(0, 20);
    check_val("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
